// File: rtl/eru_varlat_adder.sv
// eru_varlat_adder
//   Block-speculative approximate adder with error detection and optional
//   one-cycle recovery. The operand word is split into BLK-bit sub-adders.
//   Each sub-adder's carry-in is guessed from the LOOK bits just below its
//   boundary. The exact sum is computed alongside, so the block can detect a
//   wrong guess. In exact mode a wrong guess costs one extra cycle, during
//   which the exact sum is produced from the held operands.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, mode sampled on accept)
//   a, b                  unsigned WIDTH-bit operands
//   mode                  0 = approximate only, 1 = recover on speculation error
//   out_valid / out_ready result handshake
//   sum                   WIDTH+1-bit result, MSB is carry-out
//   err                   speculative sum differed from the exact sum
//   corrected             sum is the recovered exact value
//   err_clr               synchronous clear of err_count
//   err_count             saturating count of results with err=1
module eru_varlat_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 2,
  parameter int LOOK  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             corrected,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam int NBLK = WIDTH / BLK;

  typedef enum logic [1:0] {IDLE, FIX, OUT} state_t;

  // Speculative sum: each block ripples from a carry guessed by a LOOK-bit
  // window (carry-in 0) ending at the block's lower boundary. Block 0 starts
  // from a true carry-in of 0. The top block's carry-out becomes the MSB.
  function automatic logic [WIDTH:0] spec_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    logic           c;
    r = '0;
    c = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      c = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if ((j < k*BLK) && (j >= k*BLK - LOOK))
          c = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
      end
      for (int j = 0; j < BLK; j++) begin
        r[k*BLK+j] = x[k*BLK+j] ^ y[k*BLK+j] ^ c;
        c = (x[k*BLK+j] & y[k*BLK+j]) | (c & (x[k*BLK+j] ^ y[k*BLK+j]));
      end
    end
    r[WIDTH] = c;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             err_q, err_d;
  logic             corr_q, corr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_apx;
  logic [WIDTH:0]   sum_ex;
  logic [WIDTH:0]   sum_fix;
  logic             spec_err;
  logic             accept;
  logic             cnt_inc;

  assign sum_apx  = spec_add(a, b);
  assign sum_ex   = {1'b0, a} + {1'b0, b};
  assign sum_fix  = {1'b0, a_q} + {1'b0, b_q};
  assign spec_err = (sum_apx != sum_ex);

  assign in_ready = (state_q == IDLE) | ((state_q == OUT) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    corr_d  = corr_q;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE, OUT: begin
        if (accept) begin
          a_d = a;
          b_d = b;
          if (mode && spec_err) begin
            // Result is not presented yet; FIX rebuilds it from a_q/b_q.
            err_d   = 1'b1;
            corr_d  = 1'b0;
            state_d = FIX;
          end else begin
            sum_d   = sum_apx;
            err_d   = spec_err;
            corr_d  = 1'b0;
            cnt_inc = spec_err;
            state_d = OUT;
          end
        end else if ((state_q == OUT) && out_ready) begin
          state_d = IDLE;
        end
      end
      FIX: begin
        sum_d   = sum_fix;
        corr_d  = 1'b1;
        cnt_inc = 1'b1;
        state_d = OUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a coincident increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      err_q   <= 1'b0;
      corr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held operands are only read in FIX, which is always entered through an accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign out_valid = (state_q == OUT);
  assign sum       = sum_q;
  assign err       = err_q;
  assign corrected = corr_q;
  assign err_count = cnt_q;

endmodule
